// File: rtl/pulse_dac_sequencer_if.sv
// ---------------------------------------------------------------------------
// pulse_dac_sequencer_if
//   Command channel of the pulse DAC sequencer. One command is a pulse
//   description: per-channel pulse values, a channel mask and a length.
//
//   Signals:
//     cmd_valid        producer offers a command
//     cmd_ready        sequencer queue can accept a command
//     dc_value_in      pulse values, channel k at [k*DC_VALUE_WIDTH +: DC_VALUE_WIDTH]
//     channel_mask_in  1 = channel takes the pulse value, 0 = keeps its default
//     length_in        pulse length in clock cycles (0 = discarded command)
//
//   Modports:
//     master  command producer
//     slave   sequencer
// ---------------------------------------------------------------------------
interface pulse_dac_sequencer_if #(
  parameter int NUM_CHANNEL        = 22,
  parameter int DC_VALUE_WIDTH     = 12,
  parameter int PULSE_LENGTH_WIDTH = 20
);

  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [DC_VALUE_WIDTH*NUM_CHANNEL-1:0] dc_value_in;
  logic [NUM_CHANNEL-1:0]                channel_mask_in;
  logic [PULSE_LENGTH_WIDTH-1:0]         length_in;

  modport master (
    output cmd_valid,
    output dc_value_in,
    output channel_mask_in,
    output length_in,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  dc_value_in,
    input  channel_mask_in,
    input  length_in,
    output cmd_ready
  );

endinterface

// File: rtl/pulse_dac_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_dac_sequencer
//   Multi-channel DC pulse controller. Commands are queued in a small FIFO
//   and played back-to-back; between pulses every channel drives its
//   programmable default DC value. Masked-out channels keep their default
//   during a pulse as well.
//
//   Optional feature macro: PULSE_DAC_SEQ_ABORT_EN
//     defined   -> adds input 'abort' that flushes the queue, stops the
//                  current pulse and drops any same-cycle push
//     undefined -> no abort port, pulses always complete
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     abort                     (optional) abort playback and flush queue
//     default_dc_value_wr_en    load all default registers this cycle
//     default_dc_value_wr_data  new defaults, channel k at [k*DCW +: DCW]
//     cmd                       command channel (slave modport)
//     dc_value_out              registered DAC values
//     valid_dc_value_out        high on every cycle a pulse is on the DAC
//     pulse_done                one-cycle strobe after a pulse's last valid cycle
//     busy                      pulse playing or queue non-empty
//     fifo_count                queue occupancy
// ---------------------------------------------------------------------------
module pulse_dac_sequencer #(
  parameter int NUM_CHANNEL        = 22,
  parameter int DC_VALUE_WIDTH     = 12,
  parameter int PULSE_LENGTH_WIDTH = 20,
  parameter int CMD_FIFO_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
`ifdef PULSE_DAC_SEQ_ABORT_EN
  input  logic                                  abort,
`endif
  input  logic                                  default_dc_value_wr_en,
  input  logic [DC_VALUE_WIDTH*NUM_CHANNEL-1:0] default_dc_value_wr_data,
  pulse_dac_sequencer_if.slave                  cmd,
  output logic [DC_VALUE_WIDTH*NUM_CHANNEL-1:0] dc_value_out,
  output logic                                  valid_dc_value_out,
  output logic                                  pulse_done,
  output logic                                  busy,
  output logic [$clog2(CMD_FIFO_DEPTH):0]       fifo_count
);

  localparam int PTR_W   = $clog2(CMD_FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int DATA_W  = DC_VALUE_WIDTH * NUM_CHANNEL;
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(CMD_FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t state, state_next;

  logic abort_now;
`ifdef PULSE_DAC_SEQ_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Default DC registers
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] default_reg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      default_reg <= '0;
    end else if (default_dc_value_wr_en) begin
      default_reg <= default_dc_value_wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]             mem_value [CMD_FIFO_DEPTH];
  logic [NUM_CHANNEL-1:0]        mem_mask  [CMD_FIFO_DEPTH];
  logic [PULSE_LENGTH_WIDTH-1:0] mem_len   [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic                          push, pop;
  logic                          fifo_empty;
  logic [PULSE_LENGTH_WIDTH-1:0] head_len;

  assign cmd.cmd_ready = (fifo_count != FULL_COUNT);
  assign push          = cmd.cmd_valid && cmd.cmd_ready && !abort_now;
  assign fifo_empty    = (fifo_count == '0);
  assign head_len      = mem_len[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || abort_now) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; occupancy is tracked by the pointers
  // and count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_value[wr_ptr] <= cmd.dc_value_in;
      mem_mask[wr_ptr]  <= cmd.channel_mask_in;
      mem_len[wr_ptr]   <= cmd.length_in;
    end
  end

  // -------------------------------------------------------------------------
  // Playback FSM
  // -------------------------------------------------------------------------
  logic [PULSE_LENGTH_WIDTH-1:0] counter;
  logic                          load;
  logic                          pulse_end;
  logic                          last_cycle;

  assign last_cycle = (counter == PULSE_LENGTH_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    pulse_end  = 1'b0;
    if (abort_now) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            // A zero-length command is consumed without playing.
            if (head_len != '0) begin
              load       = 1'b1;
              state_next = PLAY;
            end
          end
        end
        PLAY: begin
          if (last_cycle) begin
            pulse_end = 1'b1;
            if (!fifo_empty) begin
              pop = 1'b1;
              if (head_len != '0) load = 1'b1;
              else                state_next = IDLE;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Active pulse registers
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]      active_value;
  logic [NUM_CHANNEL-1:0] active_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter      <= '0;
      active_value <= '0;
      active_mask  <= '0;
    end else if (load) begin
      counter      <= head_len;
      active_value <= mem_value[rd_ptr];
      active_mask  <= mem_mask[rd_ptr];
    end else if (state == PLAY) begin
      counter <= counter - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage: registered one cycle behind the FSM state
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] next_dc_value;
  logic              done_stage;

  always_comb begin
    next_dc_value = default_reg;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      if ((state == PLAY) && active_mask[k]) begin
        next_dc_value[k*DC_VALUE_WIDTH +: DC_VALUE_WIDTH] =
          active_value[k*DC_VALUE_WIDTH +: DC_VALUE_WIDTH];
      end
    end
  end

  // pulse_end marks the FSM's last PLAY cycle; the output register shows
  // that cycle one later, and pulse_done follows one cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_value_out       <= '0;
      valid_dc_value_out <= 1'b0;
      done_stage         <= 1'b0;
      pulse_done         <= 1'b0;
    end else if (abort_now) begin
      dc_value_out       <= default_reg;
      valid_dc_value_out <= 1'b0;
      done_stage         <= 1'b0;
      pulse_done         <= 1'b0;
    end else begin
      dc_value_out       <= next_dc_value;
      valid_dc_value_out <= (state == PLAY);
      done_stage         <= pulse_end;
      pulse_done         <= done_stage;
    end
  end

  assign busy = (state == PLAY) || !fifo_empty;

endmodule

// File: tb/tb_pulse_dac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pulse_dac_sequencer
//   Directed bench for pulse_dac_sequencer. A queue-based model predicts the
//   outputs every cycle; directed tests add hand-computed expectations.
//   Build with +define+PULSE_DAC_SEQ_ABORT_EN to cover the abort input.
// ---------------------------------------------------------------------------
module tb_pulse_dac_sequencer;

  localparam int NC    = 22;
  localparam int DCW   = 12;
  localparam int LW    = 20;
  localparam int DEPTH = 4;
  localparam int DW    = NC * DCW;

  logic          clk;
  logic          rst;
  logic          abort;
  logic          default_dc_value_wr_en;
  logic [DW-1:0] default_dc_value_wr_data;
  logic [DW-1:0] dc_value_out;
  logic          valid_dc_value_out;
  logic          pulse_done;
  logic          busy;
  logic [$clog2(DEPTH):0] fifo_count;

  pulse_dac_sequencer_if #(.NUM_CHANNEL(NC), .DC_VALUE_WIDTH(DCW), .PULSE_LENGTH_WIDTH(LW)) cmd_if ();

  pulse_dac_sequencer #(
    .NUM_CHANNEL(NC), .DC_VALUE_WIDTH(DCW), .PULSE_LENGTH_WIDTH(LW), .CMD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
`ifdef PULSE_DAC_SEQ_ABORT_EN
    .abort                    (abort),
`endif
    .default_dc_value_wr_en   (default_dc_value_wr_en),
    .default_dc_value_wr_data (default_dc_value_wr_data),
    .cmd                      (cmd_if),
    .dc_value_out             (dc_value_out),
    .valid_dc_value_out       (valid_dc_value_out),
    .pulse_done               (pulse_done),
    .busy                     (busy),
    .fifo_count               (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [DCW-1:0] v);
    return {NC{v}};
  endfunction

  function automatic logic [DW-1:0] defaults_vec(input int offset);
    logic [DW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DCW +: DCW] = DCW'(k + offset);
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Model: a command queue plus the pulse currently on the engine. The DAC
  // shows, one cycle later, whatever the engine plays now.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] value;
    logic [NC-1:0] mask;
    int unsigned   len;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          m_cur;
  bit            m_play;
  int unsigned   m_rem;
  bit            m_last_out;
  bit            m_known = 0;
  logic [DW-1:0] m_default;
  logic [DW-1:0] exp_dc;
  logic          exp_valid, exp_done, exp_busy;
  int            exp_count;

  always @(posedge clk) begin
    cmd_t nxt;
    bit   do_push;
    if (rst) begin
      mq.delete();
      m_play = 0; m_rem = 0; m_last_out = 0; m_known = 1;
      m_default = '0; exp_dc = '0; exp_valid = 0; exp_done = 0;
    end else if (abort) begin
      mq.delete();
      exp_dc = m_default; exp_valid = 0; exp_done = 0;
      m_play = 0; m_last_out = 0;
      if (default_dc_value_wr_en) m_default = default_dc_value_wr_data;
    end else begin
      do_push = cmd_if.cmd_valid && (mq.size() != DEPTH);
      for (int k = 0; k < NC; k++)
        exp_dc[k*DCW +: DCW] = (m_play && m_cur.mask[k]) ? m_cur.value[k*DCW +: DCW]
                                                          : m_default[k*DCW +: DCW];
      exp_valid  = m_play;
      exp_done   = m_last_out;
      m_last_out = m_play && (m_rem == 1);
      if (m_play && m_rem > 1) begin
        m_rem--;
      end else begin
        m_play = 0;
        if (mq.size() > 0) begin
          nxt = mq.pop_front();
          if (nxt.len != 0) begin
            m_play = 1; m_rem = nxt.len; m_cur = nxt;
          end
        end
      end
      if (do_push) begin
        nxt.value = cmd_if.dc_value_in;
        nxt.mask  = cmd_if.channel_mask_in;
        nxt.len   = int'(cmd_if.length_in);
        mq.push_back(nxt);
      end
      if (default_dc_value_wr_en) m_default = default_dc_value_wr_data;
    end
    exp_busy  = m_play || (mq.size() != 0);
    exp_count = mq.size();
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("dc_value_out", dc_value_out, exp_dc);
      check("valid", DW'(valid_dc_value_out), DW'(exp_valid));
      check("pulse_done", DW'(pulse_done), DW'(exp_done));
      check("busy", DW'(busy), DW'(exp_busy));
      check("fifo_count", DW'(fifo_count), DW'(exp_count));
      check("cmd_ready", DW'(cmd_if.cmd_ready), DW'(exp_count != DEPTH));
    end
  end

  // -------------------------------------------------------------------------
  // Observation helpers
  // -------------------------------------------------------------------------
  logic [DW-1:0] obs_dc    [0:127];
  logic          obs_valid [0:127];
  logic          obs_done  [0:127];

  task automatic clear_obs();
    for (int i = 0; i < 128; i++) begin
      obs_dc[i] = '0; obs_valid[i] = 0; obs_done[i] = 0;
    end
  endtask

  task automatic observe(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      obs_dc[i] = dc_value_out; obs_valid[i] = valid_dc_value_out; obs_done[i] = pulse_done;
      @(negedge clk);
    end
  endtask

  task automatic summarize(input int upto, output int first, output int last,
                           output int nvalid, output int ndone);
    first = -1; last = -1; nvalid = 0; ndone = 0;
    for (int i = 0; i < upto; i++) begin
      if (obs_valid[i]) begin
        if (first < 0) first = i;
        last = i; nvalid++;
      end
      if (obs_done[i]) ndone++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic [DCW-1:0] v, input logic [NC-1:0] m, input logic [LW-1:0] l);
    bit ok = 0;
    int waited = 0;
    cmd_if.cmd_valid       = 1'b1;
    cmd_if.dc_value_in     = rep(v);
    cmd_if.channel_mask_in = m;
    cmd_if.length_in       = l;
    while (!ok && waited < 200) begin
      ok = cmd_if.cmd_ready;
      @(negedge clk);
      waited++;
    end
    cmd_if.cmd_valid = 1'b0;
    check("push_accepted", DW'(ok), DW'(1));
  endtask

  task automatic write_defaults(input int offset);
    default_dc_value_wr_en   = 1'b1;
    default_dc_value_wr_data = defaults_vec(offset);
    @(negedge clk);
    default_dc_value_wr_en   = 1'b0;
  endtask

  // Pulse log for the queue stress test.
  bit             log_en = 0;
  logic [DCW-1:0] vlog[$];
  int             log_valid = 0;
  int             log_done  = 0;

  always @(negedge clk) begin
    if (log_en) begin
      if (valid_dc_value_out) begin
        log_valid++;
        if (vlog.size() == 0 || vlog[$] != dc_value_out[DCW-1:0]) vlog.push_back(dc_value_out[DCW-1:0]);
      end
      if (pulse_done) log_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    int             first, last, nvalid, ndone;
    logic [DW-1:0]  mexp;
    logic [DCW-1:0] seq_exp [5];

    rst = 1'b1; abort = 1'b0;
    default_dc_value_wr_en = 1'b0; default_dc_value_wr_data = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.dc_value_in = '0;
    cmd_if.channel_mask_in = '0; cmd_if.length_in = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_dc", dc_value_out, '0);
    check("rst_valid", DW'(valid_dc_value_out), '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_count", DW'(fifo_count), '0);
    check("rst_ready", DW'(cmd_if.cmd_ready), DW'(1));
    rst = 1'b0;
    @(negedge clk);

    // Defaults channel k = k
    write_defaults(0);
    repeat (2) @(negedge clk);
    check("idle_defaults", dc_value_out, defaults_vec(0));
    check("idle_valid", DW'(valid_dc_value_out), '0);
    check("idle_busy", DW'(busy), '0);

    // Single pulse, L=16
    clear_obs();
    push_cmd(12'hABC, '1, 20'd16);
    observe(0, 24);
    summarize(24, first, last, nvalid, ndone);
    check("p1_first_valid", DW'(first), DW'(2));
    check("p1_valid_cycles", DW'(nvalid), DW'(16));
    check("p1_done_count", DW'(ndone), DW'(1));
    check("p1_done_at", DW'(obs_done[18]), DW'(1));
    check("p1_value_first", obs_dc[2], rep(12'hABC));
    check("p1_value_last", obs_dc[17], rep(12'hABC));
    check("p1_revert", obs_dc[18], defaults_vec(0));

    // Back-to-back L=16 then L=64
    clear_obs();
    push_cmd(12'hABC, '1, 20'd16);
    push_cmd(12'hDEF, '1, 20'd64);
    observe(1, 100);
    summarize(100, first, last, nvalid, ndone);
    check("b2b_first_valid", DW'(first), DW'(2));
    check("b2b_valid_cycles", DW'(nvalid), DW'(80));
    check("b2b_contiguous", DW'(last - first + 1), DW'(80));
    check("b2b_done_count", DW'(ndone), DW'(2));
    check("b2b_done_first", DW'(obs_done[18]), DW'(1));
    check("b2b_done_second", DW'(obs_done[82]), DW'(1));
    check("b2b_abc_end", obs_dc[17], rep(12'hABC));
    check("b2b_def_start", obs_dc[18], rep(12'hDEF));
    check("b2b_def_end", obs_dc[81], rep(12'hDEF));
    check("b2b_revert", obs_dc[90], defaults_vec(0));

    // Channel mask 0x000F0F, plus a default write mid-pulse
    clear_obs();
    push_cmd(12'hDEF, 22'h000F0F, 20'd8);
    observe(0, 5);
    for (int k = 0; k < NC; k++)
      mexp[k*DCW +: DCW] = ((k < 4) || (k >= 8 && k < 12)) ? 12'hDEF : DCW'(k);
    check("mask_pattern", obs_dc[4], mexp);
    write_defaults(16'h100);
    @(negedge clk);
    for (int k = 0; k < NC; k++)
      mexp[k*DCW +: DCW] = ((k < 4) || (k >= 8 && k < 12)) ? 12'hDEF : DCW'(k + 16'h100);
    check("mask_new_default", dc_value_out, mexp);
    check("mask_still_valid", DW'(valid_dc_value_out), DW'(1));
    repeat (10) @(negedge clk);
    check("mask_revert", dc_value_out, defaults_vec(16'h100));

    // Queue fill: one long pulse, then 5 more commands into a depth-4 queue
    vlog.delete(); log_valid = 0; log_done = 0; log_en = 1;
    push_cmd(12'h111, '1, 20'd20);
    push_cmd(12'h201, '1, 20'd3);
    push_cmd(12'h202, '1, 20'd0);
    push_cmd(12'h203, '1, 20'd5);
    push_cmd(12'h204, '1, 20'd4);
    check("full_ready_low", DW'(cmd_if.cmd_ready), DW'(0));
    check("full_count", DW'(fifo_count), DW'(4));
    push_cmd(12'h205, '1, 20'd6);
    repeat (60) @(negedge clk);
    log_en = 0;
    seq_exp = '{12'h111, 12'h201, 12'h203, 12'h204, 12'h205};
    check("q_valid_cycles", DW'(log_valid), DW'(38));
    check("q_done_count", DW'(log_done), DW'(5));
    check("q_pulse_count", DW'(vlog.size()), DW'(5));
    for (int i = 0; i < 5; i++)
      if (i < vlog.size()) check("q_order", DW'(vlog[i]), DW'(seq_exp[i]));
    check("q_idle", DW'(busy), '0);

    // Reset mid-pulse with two commands queued
    push_cmd(12'h333, '1, 20'd30);
    push_cmd(12'h334, '1, 20'd5);
    push_cmd(12'h335, '1, 20'd5);
    repeat (4) @(negedge clk);
    check("pre_rst_count", DW'(fifo_count), DW'(2));
    check("pre_rst_valid", DW'(valid_dc_value_out), DW'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_dc", dc_value_out, '0);
    check("mid_rst_valid", DW'(valid_dc_value_out), '0);
    check("mid_rst_count", DW'(fifo_count), '0);
    check("mid_rst_busy", DW'(busy), '0);
    repeat (3) @(negedge clk);

`ifdef PULSE_DAC_SEQ_ABORT_EN
    // Abort mid-pulse; a push offered with the abort is dropped
    write_defaults(0);
    push_cmd(12'h5A5, '1, 20'd30);
    push_cmd(12'h5A6, '1, 20'd10);
    repeat (6) @(negedge clk);
    check("pre_abort_valid", DW'(valid_dc_value_out), DW'(1));
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1; cmd_if.length_in = 20'd7;
    @(negedge clk);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("abort_valid", DW'(valid_dc_value_out), '0);
    check("abort_defaults", dc_value_out, defaults_vec(0));
    check("abort_done", DW'(pulse_done), '0);
    check("abort_count", DW'(fifo_count), '0);
    repeat (3) @(negedge clk);
    check("abort_idle", DW'(busy), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
